// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings and default sizing.
package serial_adder_pkg;

    // FSM state encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Default sizing: one Hack word, with a counter wide enough to index every bit
    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_CNT_W = 4;

endpackage

// File: rtl/FullAdder.sv
// One-bit full adder cell used as the bit slice of the serial adder.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain combinational sum and majority carry
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequencer for the serial adder: IDLE/RUN/DONE FSM, bit counter and both handshakes.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic busy,
    output logic load,  // operands captured at this edge
    output logic run,   // one bit is added at this edge
    output logic msb    // this edge adds the most significant bit
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state, counter and handshake decode
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        run       = 1'b0;
        msb       = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                run     = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    msb     = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                // Returning to IDLE here; new operands are only taken from IDLE
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: operand/result shift registers, carry flop and one
// FullAdder slice, sequenced by serial_adder_ctrl. Adds one bit per clock, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    logic             load, run, msb;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_sum, fa_cout;

    serial_adder_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .busy      (busy),
        .load      (load),
        .run       (run),
        .msb       (msb)
    );

    FullAdder u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Datapath next state: load operands, or shift one bit through the adder slice
    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        if (load) begin
            a_sr_d  = a;
            b_sr_d  = b;
            carry_d = cin;
        end else if (run) begin
            a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
            sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
            carry_d  = fa_cout;
            // On the MSB slice carry_q is the carry into the sign bit
            if (msb) begin
                cout_d = fa_cout;
                ovf_d  = carry_q ^ fa_cout;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sum      = sum_sr_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus a randomized regression
// against an arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned W = 16;

    logic         clock     = 1'b0;
    logic         reset     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         cin_s     = 1'b0;
    logic [W-1:0] a_s       = '0;
    logic [W-1:0] b_s       = '0;
    logic         in_ready, out_valid, cout, overflow, busy;
    logic [W-1:0] sum;

    int tests     = 0;
    int fails     = 0;
    int accepted  = 0;
    int completed = 0;

    always #5 clock = ~clock;

    serial_adder #(
        .WIDTH (W),
        .CNT_W (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_s),
        .b         (b_s),
        .cin       (cin_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned sum for result/carry, signed sum range for overflow
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic c,
                         output logic [15:0] s, output logic co, output logic ov);
        int unsigned u;
        int          sg;
        u  = 32'(a) + 32'(b) + 32'(c);
        s  = u[15:0];
        co = u[16];
        sg = int'($signed(a)) + int'($signed(b)) + int'(c);
        ov = (sg > 32767) || (sg < -32768);
    endtask

    // One full transaction with `stall` cycles of out_ready=0 in DONE
    task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input int stall, input string tag);
        logic [15:0] es;
        logic        eco, eov;
        int          cyc;
        model(a, b, c, es, eco, eov);
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clock); #1;
            cyc++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        a_s = a; b_s = b; cin_s = c; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        accepted++;
        check({tag, " busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(W));
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " cout"}, 32'(cout), 32'(eco));
        check({tag, " overflow"}, 32'(overflow), 32'(eov));
        for (int i = 0; i < stall; i++) begin
            @(posedge clock); #1;
            check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " stall sum"}, 32'(sum), 32'(es));
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        completed++;
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        int          gap;

        // Reset state
        #2;
        check("rst sum", 32'(sum), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        #5 reset = 1'b0;
        @(posedge clock); #1;

        // Directed arithmetic cases
        do_add(16'h0003, 16'h0005, 1'b0, 0, "t1");
        do_add(16'hFFFF, 16'h0001, 1'b0, 0, "t2");
        do_add(16'h7FFF, 16'h0001, 1'b0, 0, "t3a");
        do_add(16'h8000, 16'h8000, 1'b0, 0, "t3b");

        // Backpressure with in_valid held high, then handoff through IDLE
        a_s = 16'h1234; b_s = 16'h4321; cin_s = 1'b1; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (W) begin
            @(posedge clock); #1;
        end
        check("t4 out_valid", 32'(out_valid), 32'd1);
        check("t4 sum", 32'(sum), 32'h5556);
        a_s = 16'h0100; b_s = 16'h0200; cin_s = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("t4 hold out_valid", 32'(out_valid), 32'd1);
            check("t4 hold sum", 32'(sum), 32'h5556);
            check("t4 hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check("t4 idle in_ready", 32'(in_ready), 32'd1);
        check("t4 idle busy", 32'(busy), 32'd0);
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("t4 next accept", 32'(busy), 32'd1);
        repeat (W) begin
            @(posedge clock); #1;
        end
        check("t4 next out_valid", 32'(out_valid), 32'd1);
        check("t4 next sum", 32'(sum), 32'h0300);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;

        // Asynchronous reset mid-RUN, then a clean add
        a_s = 16'hABCD; b_s = 16'h0001; cin_s = 1'b0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clock);
        #2;
        check("t5 busy pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("t5 busy", 32'(busy), 32'd0);
        check("t5 in_ready", 32'(in_ready), 32'd1);
        check("t5 out_valid", 32'(out_valid), 32'd0);
        check("t5 sum", 32'(sum), 32'd0);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        do_add(16'h0010, 16'h0020, 1'b0, 0, "t5 add");

        // Random regression
        accepted  = 0;
        completed = 0;
        for (int n = 0; n < 1000; n++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 1'($urandom);
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clock); #1;
            end
            do_add(ra, rb, rc, int'($urandom_range(0, 3)), "rand");
        end
        check("rand accepted", 32'(accepted), 32'd1000);
        check("rand completed", 32'(completed), 32'd1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
